// File: rtl/conv_stream_pkg.sv
// Shared widths and FSM encoding for the convolution result streamer.
package conv_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stream_state_t;

endpackage

// File: rtl/conv_skid_fifo.sv
// Two-entry FIFO between the Z memory read port and the output stream.
module conv_skid_fifo
  import conv_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a word in the same cycle its head leaves.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Drains the convolution Z memory after completion and streams it out as valid/ready beats.
module conv_result_streamer
  import conv_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned     LenW   = ADDR_WIDTH + 1;
  localparam logic [LenW-1:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};

  stream_state_t     state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   issued_q, issued_d;
  logic [LenW-1:0]   len_clamped;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              rd_en;
  logic              pop;
  logic              issue_ok;
  logic [2:0]        occ;
  logic [2:0]        pending;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_last;
  logic [DATA_WIDTH:0] fifo_rdata;

  assign len_clamped = (length > MaxLen) ? MaxLen : length;

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign occ     = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
  assign pending = occ + {2'b00, inflight_q};
  // A word leaving this cycle frees its slot in time for the read issued now.
  assign issue_ok = (issued_q < len_q) && (pending < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    rd_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len_clamped;
          issued_d = '0;
          state_d  = (len_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_en = issue_ok;
        if (rd_en) begin
          issued_d = issued_q + LenW'(1);
        end
        if (pop && m_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        issued_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && (issued_q == len_q - LenW'(1));
    end
  end

  conv_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (inflight_q),
    .pop  (pop),
    .wdata({inflight_last_q, mem_rd_data}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign head_last   = fifo_rdata[DATA_WIDTH];
  assign m_data      = fifo_rdata[DATA_WIDTH-1:0];
  assign m_last      = m_valid & head_last;
  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = issued_q[ADDR_WIDTH-1:0];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule
